// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared, registered ALU.
// Each operation runs IDLE (accept) -> EXEC (ALU samples) -> CAPT (response latched).
module alu_arbiter #(
    parameter int NUMBITS = 3
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   req0_valid,
    input  logic [2:0]             req0_cmd,
    input  logic [NUMBITS:0]       req0_x,
    input  logic [NUMBITS:0]       req0_y,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [2:0]             req1_cmd,
    input  logic [NUMBITS:0]       req1_x,
    input  logic [NUMBITS:0]       req1_y,
    output logic                   req1_ready,
    output logic [2:0]             alu_cmd,
    output logic [NUMBITS:0]       alu_x,
    output logic [NUMBITS:0]       alu_y,
    input  logic [2*NUMBITS+1:0]   alu_result,
    input  logic                   alu_z,
    input  logic                   alu_o,
    input  logic                   alu_n,
    output logic                   rsp_valid,
    output logic                   rsp_id,
    output logic [2*NUMBITS+1:0]   rsp_result,
    output logic                   rsp_z,
    output logic                   rsp_o,
    output logic                   rsp_n,
    output logic                   busy,
    output logic [7:0]             op_count,
    output logic [7:0]             err_count
);
    typedef enum logic [1:0] {IDLE, EXEC, CAPT} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_last_grant;
    logic                   r_pend_id;
    logic [2:0]             r_alu_cmd;
    logic [NUMBITS:0]       r_alu_x;
    logic [NUMBITS:0]       r_alu_y;
    logic                   r_rsp_valid;
    logic                   r_rsp_id;
    logic [2*NUMBITS+1:0]   r_rsp_result;
    logic                   r_rsp_z;
    logic                   r_rsp_o;
    logic                   r_rsp_n;
    logic [7:0]             r_op_count;
    logic [7:0]             r_err_count;

    logic                   w_gnt0;
    logic                   w_gnt1;
    logic                   w_accept;
    logic                   w_div0;

    // Round-robin on ties: the side not granted last time wins.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        w_next = r_state;
        if (reset_n && r_state == IDLE) begin
            w_gnt0 = req0_valid && (!req1_valid || r_last_grant);
            w_gnt1 = req1_valid && (!req0_valid || !r_last_grant);
        end
        case (r_state)
            IDLE:    if (w_gnt0 || w_gnt1) w_next = EXEC;
            EXEC:    w_next = CAPT;
            CAPT:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_accept = w_gnt0 || w_gnt1;
    // The ALU's result is meaningless on divide-by-zero; never pass it on.
    assign w_div0   = (r_alu_cmd == 3'b100) && alu_o;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_pend_id    <= 1'b0;
            r_alu_cmd    <= '0;
            r_alu_x      <= '0;
            r_alu_y      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_z      <= 1'b0;
            r_rsp_o      <= 1'b0;
            r_rsp_n      <= 1'b0;
            r_op_count   <= '0;
            r_err_count  <= '0;
        end else begin
            r_state     <= w_next;
            r_rsp_valid <= (r_state == CAPT);
            if (w_accept) begin
                r_alu_cmd    <= w_gnt1 ? req1_cmd : req0_cmd;
                r_alu_x      <= w_gnt1 ? req1_x   : req0_x;
                r_alu_y      <= w_gnt1 ? req1_y   : req0_y;
                r_pend_id    <= w_gnt1;
                r_last_grant <= w_gnt1;
            end
            if (r_state == CAPT) begin
                r_rsp_id     <= r_pend_id;
                r_rsp_result <= w_div0 ? '0 : alu_result;
                r_rsp_z      <= w_div0 ? 1'b0 : alu_z;
                r_rsp_n      <= w_div0 ? 1'b0 : alu_n;
                r_rsp_o      <= alu_o;
                if (r_op_count != 8'hFF) r_op_count <= r_op_count + 8'd1;
                if (alu_o && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign alu_cmd    = r_alu_cmd;
    assign alu_x      = r_alu_x;
    assign alu_y      = r_alu_y;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_z      = r_rsp_z;
    assign rsp_o      = r_rsp_o;
    assign rsp_n      = r_rsp_n;
    assign busy       = (r_state != IDLE);
    assign op_count   = r_op_count;
    assign err_count  = r_err_count;

endmodule
